// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp encodings, FSM state codes and a constant clog2 helper
// shared by the traffic phase controller files.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3,
    ST_EMG    = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// traffic_tick_gen: TICK_DIV prescaler producing a one-cycle tick while enabled,
// with a synchronous clear used when a new interval is entered.
module traffic_tick_gen
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;

  // tick must not depend on clr: clr is derived from the FSM's reaction to tick
  assign tick = en && (pre_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pre_q <= '0;
    else if (clr)
      pre_q <= '0;
    else if (en)
      pre_q <= (pre_q == LAST) ? '0 : pre_q + 1'b1;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: rotates one green right-of-way over N_DIR approaches with
// yellow/all-red clearance, hold and emergency pre-emption. Macro TRAFFIC_PED_EN adds walk requests.
//
// state  | meaning
// IDLE   | all red, waiting for i_start
// GREEN  | o_phase green, counting down
// YELLOW | o_phase yellow, counting down
// ALLRED | every direction red, counting down
// EMG    | latched emergency direction green until i_emg drops
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR    = 4,
  parameter int CNT_W    = 4,
  parameter int GREEN_T  = 9,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int TICK_DIV = 1
`ifdef TRAFFIC_PED_EN
  ,
  parameter int PED_EXT  = 3
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic                      i_hold,
  input  logic                      i_emg,
  input  logic [clog2(N_DIR)-1:0]   i_emg_dir,
  output logic [2*N_DIR-1:0]        o_light,
  output logic [CNT_W*N_DIR-1:0]    o_cnt,
  output logic [clog2(N_DIR)-1:0]   o_phase,
  output logic                      o_busy
`ifdef TRAFFIC_PED_EN
  ,
  input  logic [N_DIR-1:0]          i_ped_req,
  output logic [N_DIR-1:0]          o_walk
`endif
);

  localparam int PH_W = clog2(N_DIR);

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PH_W-1:0]     emg_dir_q, emg_dir_d;
  logic                emg_pend_q, emg_pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept, run_en, counting, tick, load;
  logic [2*N_DIR-1:0]  light_d;
  logic [CNT_W*N_DIR-1:0] cnt_out_d;
`ifdef TRAFFIC_PED_EN
  logic [N_DIR-1:0]    ped_pend_q, ped_clr, walk_q, walk_d;
`endif

  // emergency overrides hold so pre-emption can never be frozen out
  assign run_en   = !(i_hold && !i_emg);
  assign counting = (state_q == ST_GREEN) || (state_q == ST_YELLOW) || (state_q == ST_ALLRED);
  assign accept   = i_emg && !emg_pend_q && counting;
  assign load     = (state_d != state_q);

  traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_en && counting),
    .clr     (load),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    emg_pend_d = emg_pend_q;
    emg_dir_d  = emg_dir_q;
`ifdef TRAFFIC_PED_EN
    ped_clr    = '0;
    walk_d     = walk_q;
`endif
    if (accept) begin
      emg_pend_d = 1'b1;
      emg_dir_d  = i_emg_dir;
    end
    case (state_q)
      ST_IDLE: begin
        if (i_start && run_en) begin
          state_d = ST_GREEN;
          phase_d = '0;
        end
      end
      ST_GREEN: begin
        if (accept && (i_emg_dir == phase_q)) begin
          state_d    = ST_EMG;
          emg_pend_d = 1'b0;
          cnt_d      = '0;
        end else if (accept || (tick && cnt_q == '0)) begin
          state_d = ST_YELLOW;
          cnt_d   = CNT_W'(YELLOW_T - 1);
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_YELLOW: begin
        if (tick && cnt_q == '0) begin
          state_d = ST_ALLRED;
          cnt_d   = CNT_W'(ALLRED_T - 1);
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ALLRED: begin
        if (tick && cnt_q == '0) begin
          if (emg_pend_d) begin
            state_d    = ST_EMG;
            phase_d    = emg_dir_d;
            emg_pend_d = 1'b0;
            cnt_d      = '0;
          end else if (i_start) begin
            state_d = ST_GREEN;
            phase_d = (phase_q == PH_W'(N_DIR - 1)) ? '0 : phase_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_EMG: begin
        if (!i_emg) begin
          state_d = ST_YELLOW;
          cnt_d   = CNT_W'(YELLOW_T - 1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == ST_GREEN && state_q != ST_GREEN) begin
      cnt_d = CNT_W'(GREEN_T - 1);
`ifdef TRAFFIC_PED_EN
      if (ped_pend_q[phase_d]) begin
        cnt_d            = CNT_W'(GREEN_T + PED_EXT - 1);
        walk_d           = '0;
        walk_d[phase_d]  = 1'b1;
        ped_clr[phase_d] = 1'b1;
      end
`endif
    end
`ifdef TRAFFIC_PED_EN
    if (state_d != ST_GREEN) walk_d = '0;
`endif
  end

  always_comb begin
    light_d   = '0;
    cnt_out_d = '0;
    for (int d = 0; d < N_DIR; d++) begin
      if (phase_d == PH_W'(d)) begin
        case (state_d)
          ST_GREEN, ST_EMG: light_d[2*d +: 2] = LIGHT_GREEN;
          ST_YELLOW:        light_d[2*d +: 2] = LIGHT_YELLOW;
          default:          light_d[2*d +: 2] = LIGHT_RED;
        endcase
        cnt_out_d[CNT_W*d +: CNT_W] = cnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      emg_pend_q <= 1'b0;
      emg_dir_q  <= '0;
      o_light    <= '0;
      o_cnt      <= '0;
      o_busy     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      emg_pend_q <= emg_pend_d;
      emg_dir_q  <= emg_dir_d;
      o_light    <= light_d;
      o_cnt      <= cnt_out_d;
      o_busy     <= (state_d != ST_IDLE);
    end
  end

  assign o_phase = phase_q;

`ifdef TRAFFIC_PED_EN
  // a request arriving while its green is entered stays pending for the next green
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend_q <= '0;
      walk_q     <= '0;
    end else begin
      ped_pend_q <= (ped_pend_q & ~ped_clr) | i_ped_req;
      walk_q     <= walk_d;
    end
  end

  assign o_walk = walk_q;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed plus randomized stimulus against a cycle-budget
// reference model; a scoreboard queue feeds an independent output monitor.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int GT = 5;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int TD = 1;
  localparam int PW = 2;
`ifdef TRAFFIC_PED_EN
  localparam int PE = 3;
`endif

  localparam int K_IDLE = 0, K_GREEN = 1, K_YELLOW = 2, K_ALLRED = 3, K_EMG = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic i_start = 1'b0, i_hold = 1'b0, i_emg = 1'b0;
  logic [PW-1:0] i_emg_dir = '0;
  logic [2*N-1:0] o_light;
  logic [CW*N-1:0] o_cnt;
  logic [PW-1:0] o_phase;
  logic o_busy;
`ifdef TRAFFIC_PED_EN
  logic [N-1:0] i_ped_req = '0;
  logic [N-1:0] o_walk;
`endif

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .N_DIR(N), .CNT_W(CW), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .TICK_DIV(TD)
`ifdef TRAFFIC_PED_EN
    , .PED_EXT(PE)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_start   (i_start),
    .i_hold    (i_hold),
    .i_emg     (i_emg),
    .i_emg_dir (i_emg_dir),
    .o_light   (o_light),
    .o_cnt     (o_cnt),
    .o_phase   (o_phase),
    .o_busy    (o_busy)
`ifdef TRAFFIC_PED_EN
    ,
    .i_ped_req (i_ped_req),
    .o_walk    (o_walk)
`endif
  );

  typedef struct packed {
    logic [2*N-1:0]  light;
    logic [CW*N-1:0] cnt;
    logic [PW-1:0]   phase;
    logic            busy;
    logic [N-1:0]    walk;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;

  // reference model: interval length tracked as remaining clock cycles
  int m_kind = K_IDLE;
  int m_ph = 0;
  int m_rem = 0;
  int m_edir = 0;
  bit m_epend = 0;
  bit m_walk = 0;
  logic [N-1:0] m_pend = '0;

  bit cur_rst = 0, prev_rst = 0, cur_start = 0, cur_hold = 0, cur_emg = 0;
  int cur_edir = 0;
  logic [N-1:0] cur_ped = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic enter_green(input int d);
    m_kind = K_GREEN;
    m_ph   = d;
    m_rem  = GT * TD;
    m_walk = 0;
`ifdef TRAFFIC_PED_EN
    if (m_pend[d]) begin
      m_rem     = (GT + PE) * TD;
      m_walk    = 1;
      m_pend[d] = 1'b0;
    end
`endif
  endtask

  task automatic enter_timed(input int kind, input int ticks);
    m_kind = kind;
    m_rem  = ticks * TD;
    m_walk = 0;
  endtask

  task automatic model_step();
    bit held, acc;
    if (!cur_rst) begin
      m_kind = K_IDLE; m_ph = 0; m_rem = 0; m_edir = 0; m_epend = 0; m_walk = 0; m_pend = '0;
      return;
    end
    held = cur_hold && !cur_emg;
    acc  = 0;
    if (cur_emg && !m_epend && (m_kind == K_GREEN || m_kind == K_YELLOW || m_kind == K_ALLRED)) begin
      acc = 1; m_epend = 1; m_edir = cur_edir;
    end
    case (m_kind)
      K_IDLE: if (cur_start && !held) enter_green(0);
      K_GREEN: begin
        if (acc && m_edir == m_ph) begin
          m_kind = K_EMG; m_epend = 0; m_walk = 0;
        end else if (acc) enter_timed(K_YELLOW, YT);
        else if (!held) begin
          if (m_rem == 1) enter_timed(K_YELLOW, YT);
          else m_rem--;
        end
      end
      K_YELLOW: if (!held) begin
        if (m_rem == 1) enter_timed(K_ALLRED, AT);
        else m_rem--;
      end
      K_ALLRED: if (!held) begin
        if (m_rem == 1) begin
          if (m_epend) begin
            m_kind = K_EMG; m_ph = m_edir; m_epend = 0; m_rem = 0;
          end else if (cur_start) enter_green((m_ph + 1) % N);
          else begin
            m_kind = K_IDLE; m_rem = 0;
          end
        end else m_rem--;
      end
      default: if (!cur_emg) enter_timed(K_YELLOW, YT);
    endcase
`ifdef TRAFFIC_PED_EN
    m_pend = m_pend | cur_ped;
`endif
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.phase = PW'(m_ph);
    e.busy  = (m_kind != K_IDLE);
    if (m_kind == K_GREEN || m_kind == K_EMG) e.light[2*m_ph +: 2] = 2'b10;
    else if (m_kind == K_YELLOW) e.light[2*m_ph +: 2] = 2'b01;
    if (m_kind == K_GREEN || m_kind == K_YELLOW || m_kind == K_ALLRED)
      e.cnt[CW*m_ph +: CW] = CW'((m_rem - 1) / TD);
    if (m_kind == K_GREEN && m_walk) e.walk[m_ph] = 1'b1;
    return e;
  endfunction

  task automatic check_reset_now(input string tag);
    chk({tag, "_light"}, 32'(o_light), 0);
    chk({tag, "_cnt"},   32'(o_cnt),   0);
    chk({tag, "_phase"}, 32'(o_phase), 0);
    chk({tag, "_busy"},  32'(o_busy),  0);
  endtask

  task automatic cycle();
    @(negedge clk);
    reset_n   = cur_rst;
    i_start   = cur_start;
    i_hold    = cur_hold;
    i_emg     = cur_emg;
    i_emg_dir = PW'(cur_edir);
`ifdef TRAFFIC_PED_EN
    i_ped_req = cur_ped;
`endif
    if (!cur_rst && prev_rst) begin
      #1;
      check_reset_now("async_rst");
    end
    prev_rst = cur_rst;
    model_step();
    exp_q.push_back(model_out());
`ifdef TRAFFIC_PED_EN
    cur_ped = '0;
`endif
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_green(input int ph, input int cnt, input string name);
    int n;
    n = 0;
    while (!(m_kind == K_GREEN && m_ph == ph && (cnt < 0 || (m_rem - 1) / TD == cnt)) && n < 200) begin
      cycle();
      n++;
    end
    chk({name, "_reached"}, 32'(n < 200), 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("light", 32'(o_light), 32'(e.light));
        chk("cnt",   32'(o_cnt),   32'(e.cnt));
        chk("phase", 32'(o_phase), 32'(e.phase));
        chk("busy",  32'(o_busy),  32'(e.busy));
`ifdef TRAFFIC_PED_EN
        chk("walk",  32'(o_walk),  32'(e.walk));
`endif
      end
    end
  end

  initial begin : driver
    #2 reset_n = 1'b0;
    #1 check_reset_now("reset");
    cycles(3);

    // normal rotation with wrap
    cur_rst = 1; cur_start = 1;
    cycles(40);

    // async reset during dir1 green, then restart
    run_until_green(1, -1, "rst_dir1");
    cycles(2);
    cur_rst = 0;
    cycles(2);
    cur_rst = 1;
    cycles(12);

    // hold at count 3
    run_until_green(0, 3, "hold");
    cur_hold = 1;
    cycles(3);
    cur_hold = 0;
    cycles(10);

    // emergency to dir2 from dir0 green; dir change inside EMG ignored
    run_until_green(0, 3, "emg");
    cur_emg = 1; cur_edir = 2;
    cycles(6);
    cur_edir = 1;
    cycles(3);
    cur_emg = 0;
    cycles(14);

    // stop during dir1 green, then restart
    run_until_green(1, -1, "stop");
    cur_start = 0;
    cycles(16);
    cur_start = 1;
    cycles(6);

`ifdef TRAFFIC_PED_EN
    run_until_green(0, -1, "ped");
    cur_ped = 4'b0010;
    cycles(24);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cur_rst   = ($urandom_range(0, 599) != 0);
      cur_start = ($urandom_range(0, 19) != 0);
      cur_hold  = ($urandom_range(0, 9) == 0);
      if (!cur_emg) cur_emg = ($urandom_range(0, 39) == 0);
      else          cur_emg = ($urandom_range(0, 7) != 0);
      cur_edir  = $urandom_range(0, N - 1);
`ifdef TRAFFIC_PED_EN
      if ($urandom_range(0, 14) == 0) cur_ped = N'(1 << $urandom_range(0, N - 1));
`endif
      cycle();
    end

    cur_rst = 1; cur_start = 0; cur_hold = 0; cur_emg = 0;
    cycles(40);
    @(posedge clk);
    #3;
    chk("queue_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
